uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: state encoding,
// oversampling constant and the tick-counter sample points.
package uart_pkg;

  localparam int unsigned OS    = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [CNT_W-1:0] SMP_FIRST = CNT_W'(7);
  localparam logic [CNT_W-1:0] SMP_MID   = CNT_W'(8);
  localparam logic [CNT_W-1:0] SMP_LAST  = CNT_W'(9);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(15);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning: 2-flop synchronizer for rx and a rising-edge detector
// that turns the 16x baud square wave into one-clk sample ticks.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  input  logic baud16_i,
  output logic rx_sync_o,
  output logic tick_c_o
);

  logic rx_meta_q;
  logic rx_sync_q;
  logic baud_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      baud_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      baud_q    <= baud16_i;
    end
  end

  assign rx_sync_o = rx_sync_q;
  assign tick_c_o  = baud16_i & ~baud_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 3-sample majority vote per bit, single-entry
// output buffer with valid/ack handshake, frame-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OS        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud16,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_vld,
  input  logic                 dout_ack,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned OS_LAST = OS - 1;

  logic rx_sync;
  logic tick_c;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx),
    .baud16_i  (baud16),
    .rx_sync_o (rx_sync),
    .tick_c_o  (tick_c)
  );

  state_e               state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
  logic [1:0]           smp_q,       smp_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] dout_q,      dout_d;
  logic                 dout_vld_q,  dout_vld_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
  logic                 bit_val_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      smp_q       <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      smp_q       <= smp_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Samples at cnt 7 and 8 are held; the cnt 9 sample is taken live.
  assign bit_val_c = majority3(smp_q[0], smp_q[1], rx_sync);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    smp_d       = smp_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    dout_vld_d  = dout_vld_q & ~dout_ack;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (tick_c) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == SMP_FIRST) smp_d[0] = rx_sync;
      if (cnt_q == SMP_MID)   smp_d[1] = rx_sync;

      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!rx_sync) state_d = START;
        end
        START: begin
          if (cnt_q == SMP_LAST && bit_val_c) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(OS_LAST)) begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end
        end
        DATA: begin
          if (cnt_q == SMP_LAST) shift_d = {bit_val_c, shift_q[DATA_BITS-1:1]};
          if (cnt_q == CNT_W'(OS_LAST)) begin
            cnt_d = '0;
            if (bit_idx_q == IDX_W'(DATA_BITS - 1)) state_d = STOP;
            else bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
        STOP: begin
          // Leave at mid stop bit so the next start edge can be caught early.
          if (cnt_q == SMP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (!bit_val_c) begin
              frame_err_d = 1'b1;
            end else if (!dout_vld_q || dout_ack) begin
              dout_d     = shift_q;
              dout_vld_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
